// File: rtl/robot_pkg.sv
// Shared definitions for the robot motion blocks: FSM state encoding,
// default step durations and small output-decode helpers.
package robot_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_FORWARD = 2'b01;
    localparam logic [1:0] ST_TURN    = 2'b10;
    localparam logic [1:0] ST_SETTLE  = 2'b11;

    localparam int FWD_TICKS_DEF    = 4;
    localparam int TURN_TICKS_DEF   = 8;
    localparam int SETTLE_TICKS_DEF = 2;

    // Counter that sticks at its top value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    // Motor pattern for a state, packed as {l_en, r_en, l_dir, r_dir}.
    function automatic logic [3:0] motor_decode(input logic [1:0] st);
        case (st)
            ST_FORWARD: motor_decode = 4'b1111;
            ST_TURN:    motor_decode = 4'b1110;
            default:    motor_decode = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/tick_counter.sv
// 8-bit loadable down-counter with a zero flag; stops at zero rather
// than wrapping so an idle counter stays quiet.
module tick_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/motion_sequencer.sv
// Step sequencer between the navigation FSM and the drive motors: runs one
// forward step or one 90-degree right pivot per command, then a motors-off dwell.
module motion_sequencer
    import robot_pkg::*;
#(
    parameter int FWD_TICKS    = FWD_TICKS_DEF,
    parameter int TURN_TICKS   = TURN_TICKS_DEF,
    parameter int SETTLE_TICKS = SETTLE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       front_cmd,
    input  logic       turn_cmd,
    input  logic       stop,
    output logic       cmd_ready,
    output logic       mot_l_en,
    output logic       mot_r_en,
    output logic       mot_l_dir,
    output logic       mot_r_dir,
    output logic       done,
    output logic       aborted,
    output logic [1:0] heading,
    output logic [7:0] fwd_count
);

    localparam logic [7:0] FWD_LOAD    = 8'(FWD_TICKS - 1);
    localparam logic [7:0] TURN_LOAD   = 8'(TURN_TICKS - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_TICKS - 1);

    logic [1:0] state_q,   state_d;
    logic [3:0] mot_q,     mot_d;
    logic       done_q,    done_d;
    logic       aborted_q, aborted_d;
    logic [1:0] heading_q, heading_d;
    logic [7:0] fwd_q,     fwd_d;

    logic       accept_s;
    logic       cnt_load_s;
    logic [7:0] cnt_val_s;
    logic       cnt_dec_s;
    logic       cnt_zero_s;

    assign cmd_ready = (state_q == ST_IDLE) && !stop;
    assign accept_s  = cmd_valid && cmd_ready;

    tick_counter u_tick_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, counter control and status updates; stop beats step completion.
    always_comb begin
        state_d    = state_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = 8'd0;
        cnt_dec_s  = 1'b0;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        heading_d  = heading_q;
        fwd_d      = fwd_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && turn_cmd) begin
                    state_d    = ST_TURN;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = TURN_LOAD;
                end else if (accept_s && front_cmd) begin
                    state_d    = ST_FORWARD;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = FWD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FORWARD: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_zero_s) begin
                    state_d    = ST_SETTLE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETTLE_LOAD;
                    fwd_d      = sat_inc8(fwd_q);
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_TURN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_zero_s) begin
                    state_d    = ST_SETTLE;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = SETTLE_LOAD;
                    heading_d  = heading_q + 2'd1;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_zero_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Motor pattern is decoded from the next state so the registered outputs track state_q.
    always_comb begin
        mot_d = motor_decode(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mot_q     <= 4'b0000;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            heading_q <= 2'd0;
            fwd_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            mot_q     <= mot_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            heading_q <= heading_d;
            fwd_q     <= fwd_d;
        end
    end

    assign mot_l_en  = mot_q[3];
    assign mot_r_en  = mot_q[2];
    assign mot_l_dir = mot_q[1];
    assign mot_r_dir = mot_q[0];
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign heading   = heading_q;
    assign fwd_count = fwd_q;

endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter FWD_TICKS SHALL default to 4 and set the forward-step duration in clk cycles (legal range 1..255).
REQ-003 Parameter TURN_TICKS SHALL default to 8 and set the 90-degree pivot duration in cycles (legal range 1..255).
REQ-004 Parameter SETTLE_TICKS SHALL default to 2 and set the motors-off dwell after each step (legal range 1..255).
REQ-005 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  navigation FSM presents a command
- front_cmd  in  1  request a forward step
- turn_cmd  in  1  request a 90-degree right pivot
- stop  in  1  emergency abort, level-sensitive
- cmd_ready  out  1  sequencer can accept a command
- mot_l_en, mot_r_en  out  1 each  left/right motor enable
- mot_l_dir, mot_r_dir  out  1 each  motor direction, 1 = forward
- done  out  1  one-cycle pulse when a step completes normally
- aborted  out  1  one-cycle pulse when a step is killed by stop
- heading  out  2  completed-turn count mod 4
- fwd_count  out  8  completed forward steps, saturating

Function
REQ-006 The FSM SHALL have four states: IDLE, FORWARD, TURN and SETTLE.
REQ-007 cmd_ready SHALL be 1 only in IDLE with stop=0; a command is accepted on a rising edge with cmd_valid and cmd_ready both 1.
REQ-008 On accept with turn_cmd=1, the FSM SHALL enter TURN, regardless of front_cmd (turn has priority).
REQ-009 On accept with turn_cmd=0 and front_cmd=1, the FSM SHALL enter FORWARD; on accept with both 0, it SHALL stay in IDLE and produce no done pulse.
REQ-010 On accept, the down-counter SHALL load TICKS-1; the step state SHALL last exactly TICKS cycles, then go to SETTLE, loading SETTLE_TICKS-1.
REQ-011 SETTLE SHALL last exactly SETTLE_TICKS cycles, then return to IDLE.
REQ-012 done SHALL be 1 for exactly the first IDLE cycle after SETTLE.
REQ-013 Motor outputs SHALL be registered and decoded from state:
- FORWARD: both en=1, both dir=1.
- TURN: both en=1, l_dir=1, r_dir=0.
- IDLE and SETTLE: all en=0, all dir=0.
REQ-014 heading SHALL increment mod 4 (3 wraps to 0) on the TURN-to-SETTLE transition.
REQ-015 fwd_count SHALL increment on the FORWARD-to-SETTLE transition and saturate at 255.
REQ-016 stop=1 in FORWARD, TURN or SETTLE SHALL force IDLE at the next edge and pulse aborted for one cycle there.
- No done pulse on abort.
- heading and fwd_count unchanged by an aborted step.
REQ-017 stop=1 in IDLE SHALL block acceptance and produce no pulse.
REQ-018 cmd_valid, front_cmd and turn_cmd SHALL be ignored in every state other than IDLE.
REQ-019 Latency: command accepted at edge k gives motors enabled from k+1 through k+TICKS, and done at cycle k+TICKS+SETTLE_TICKS+1.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously force:
- state = IDLE and counter = 0;
- all motor outputs = 0, done = 0, aborted = 0;
- heading = 0 and fwd_count = 0.
REQ-021 Reset asserted mid-step SHALL discard the step with no done or aborted pulse; cmd_ready SHALL be 1 on the first cycle after rst_n deasserts (if stop=0).

Structure
REQ-022 Shared package robot_pkg SHALL hold:
- the 2-bit state encoding constants (IDLE=00, FORWARD=01, TURN=10, SETTLE=11);
- the default tick constants.
REQ-023 The 8-bit loadable down-counter with zero flag SHALL be a sub-module named tick_counter; all other logic stays in motion_sequencer.

Verification (defaults FWD_TICKS=4, TURN_TICKS=8, SETTLE_TICKS=2)
REQ-024 Forward step: front_cmd=1 with cmd_valid=1 for one cycle -> both motors en, dir=1 for 4 cycles, then 2 cycles off, then done pulse; fwd_count=1.
REQ-025 Priority: front_cmd=1 and turn_cmd=1 together -> TURN for 8 cycles with l_dir=1, r_dir=0; heading=1; fwd_count unchanged.
REQ-026 Wrap: four consecutive turn commands -> heading goes 1, 2, 3, 0; exactly 4 done pulses.
REQ-027 Abort: stop=1 on the 3rd TURN cycle -> motors off at next edge, aborted pulses once, no done, heading unchanged, cmd_ready=1 once stop=0.
REQ-028 Saturation and ignore:
- 256 forward steps -> fwd_count holds 255.
- cmd_valid pulses during FORWARD -> ignored (no extra done).
- command with both bits 0 -> no motion, no done.
REQ-029 Reset mid-FORWARD: rst_n low asynchronously (between edges) -> all outputs 0 immediately; no pulse after release.
